// File: rtl/pe_array_seq_if.sv
// Streamed configuration channel between the top-level controller and pe_array_seq.
// A beat transfers on a rising clock edge when cfg_valid and cfg_ready are both high.
interface pe_array_seq_if #(
    parameter int CFG_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/pe_array_seq.sv
// Config-load and run sequencer for a ROWS x COLS PE array (unit 0 of each row is the LSU).
// Optional performance counters are enabled with `define PE_ARRAY_SEQ_PERF_EN.
module pe_array_seq #(
    parameter int  ROWS   = 4,
    parameter int  COLS   = 3,
    parameter int  CFG_W  = 32,
    parameter int  ITER_W = 16,
    localparam int SEL_W  = ($clog2(COLS + 1) > 1) ? $clog2(COLS + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    pe_array_seq_if.slave     cfg,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_count,
    input  logic              stall,
    output logic [ROWS-1:0]   init_en,
    output logic [SEL_W-1:0]  init_sel,
    output logic [CFG_W-1:0]  pe_config,
    output logic [ROWS-1:0]   run_en,
    output logic [SEL_W-1:0]  run_sel,
    output logic              busy,
    output logic              done,
`ifdef PE_ARRAY_SEQ_PERF_EN
    output logic [31:0]       perf_run_cycles,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic              cfg_err
);
    localparam int ROW_W = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        row_onehot = ROWS'(1) << row;
    endfunction

    state_t            state_r, state_s;
    logic [ROW_W-1:0]  ld_row_r, ld_row_s, run_row_r, run_row_s, beat_row_s;
    logic [SEL_W-1:0]  ld_unit_r, ld_unit_s, run_unit_r, run_unit_s, beat_unit_s;
    logic [ITER_W-1:0] iter_left_r, iter_left_s;
    logic [ROWS-1:0]   init_en_r, init_en_s, run_en_r, run_en_s;
    logic [SEL_W-1:0]  init_sel_r, init_sel_s, run_sel_r, run_sel_s;
    logic [CFG_W-1:0]  pe_config_r, pe_config_s;
    logic              busy_r, done_r, cfg_err_r, cfg_err_s, live_r;
    logic              cfg_ready_s, accept_s, last_beat_s, start_acc_s;

    // live_r keeps cfg_ready low until the first clock after reset release
    assign cfg_ready_s = live_r && ((state_r == ST_IDLE) || (state_r == ST_LOAD) || (state_r == ST_READY));
    assign accept_s    = cfg.cfg_valid && cfg_ready_s;
    assign cfg.cfg_ready = cfg_ready_s;

    // Next-state and next-output computation for load and run sweeps
    always_comb begin
        state_s     = state_r;
        ld_row_s    = ld_row_r;
        ld_unit_s   = ld_unit_r;
        run_row_s   = run_row_r;
        run_unit_s  = run_unit_r;
        iter_left_s = iter_left_r;
        init_en_s   = '0;
        init_sel_s  = init_sel_r;
        pe_config_s = pe_config_r;
        run_en_s    = '0;
        run_sel_s   = run_sel_r;
        cfg_err_s   = cfg_err_r;
        start_acc_s = 1'b0;
        // A beat arriving outside LOAD always restarts the frame at beat 0
        beat_row_s  = (state_r == ST_LOAD) ? ld_row_r : ROW_W'(0);
        beat_unit_s = (state_r == ST_LOAD) ? ld_unit_r : SEL_W'(0);
        last_beat_s = (beat_row_s == ROW_W'(ROWS - 1)) && (beat_unit_s == SEL_W'(COLS));

        case (state_r)
            ST_IDLE, ST_LOAD, ST_READY: begin
                if (accept_s) begin
                    init_en_s   = row_onehot(beat_row_s);
                    init_sel_s  = beat_unit_s;
                    pe_config_s = cfg.cfg_data;
                    cfg_err_s   = (state_r == ST_LOAD) ? cfg_err_r : 1'b0;
                    if (last_beat_s) begin
                        if (cfg.cfg_last) begin
                            state_s = ST_READY;
                        end else begin
                            state_s   = ST_IDLE;
                            cfg_err_s = 1'b1;
                        end
                    end else if (cfg.cfg_last) begin
                        state_s   = ST_IDLE;
                        cfg_err_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                        if (beat_unit_s == SEL_W'(COLS)) begin
                            ld_unit_s = SEL_W'(0);
                            ld_row_s  = beat_row_s + ROW_W'(1);
                        end else begin
                            ld_unit_s = beat_unit_s + SEL_W'(1);
                            ld_row_s  = beat_row_s;
                        end
                    end
                end else if ((state_r == ST_READY) && start) begin
                    // A config beat in the same cycle wins: reloading invalidates the run
                    start_acc_s = 1'b1;
                    iter_left_s = iter_count;
                    run_row_s   = ROW_W'(0);
                    run_unit_s  = SEL_W'(0);
                    state_s     = (iter_count == ITER_W'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    run_en_s  = row_onehot(run_row_r);
                    run_sel_s = run_unit_r;
                    if (run_unit_r == SEL_W'(COLS)) begin
                        run_unit_s = SEL_W'(0);
                        if (run_row_r == ROW_W'(ROWS - 1)) begin
                            run_row_s   = ROW_W'(0);
                            iter_left_s = iter_left_r - ITER_W'(1);
                            state_s     = (iter_left_r == ITER_W'(1)) ? ST_DONE : ST_RUN;
                        end else begin
                            run_row_s = run_row_r + ROW_W'(1);
                        end
                    end else begin
                        run_unit_s = run_unit_r + SEL_W'(1);
                    end
                end else begin
                    run_en_s = '0;
                end
            end
            ST_DONE: begin
                state_s = ST_READY;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            live_r      <= 1'b0;
            ld_row_r    <= '0;
            ld_unit_r   <= '0;
            run_row_r   <= '0;
            run_unit_r  <= '0;
            iter_left_r <= '0;
            init_en_r   <= '0;
            init_sel_r  <= '0;
            pe_config_r <= '0;
            run_en_r    <= '0;
            run_sel_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            live_r      <= 1'b1;
            ld_row_r    <= ld_row_s;
            ld_unit_r   <= ld_unit_s;
            run_row_r   <= run_row_s;
            run_unit_r  <= run_unit_s;
            iter_left_r <= iter_left_s;
            init_en_r   <= init_en_s;
            init_sel_r  <= init_sel_s;
            pe_config_r <= pe_config_s;
            run_en_r    <= run_en_s;
            run_sel_r   <= run_sel_s;
            busy_r      <= (state_s == ST_LOAD) || (state_s == ST_RUN);
            done_r      <= (state_s == ST_DONE);
            cfg_err_r   <= cfg_err_s;
        end
    end

`ifdef PE_ARRAY_SEQ_PERF_EN
    logic [31:0] perf_run_r, perf_stall_r;

    // Saturating RUN-cycle counters, cleared by an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_run_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else if (start_acc_s) begin
            perf_run_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else if (state_r == ST_RUN) begin
            if (stall) begin
                perf_stall_r <= (perf_stall_r == 32'hFFFF_FFFF) ? perf_stall_r : perf_stall_r + 32'd1;
            end else begin
                perf_run_r <= (perf_run_r == 32'hFFFF_FFFF) ? perf_run_r : perf_run_r + 32'd1;
            end
        end else begin
            perf_run_r   <= perf_run_r;
            perf_stall_r <= perf_stall_r;
        end
    end

    assign perf_run_cycles   = perf_run_r;
    assign perf_stall_cycles = perf_stall_r;
`endif

    assign init_en   = init_en_r;
    assign init_sel  = init_sel_r;
    assign pe_config = pe_config_r;
    assign run_en    = run_en_r;
    assign run_sel   = run_sel_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;
endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
- Parametrised config-load and run sequencer for a ROWS x COLS PE array. Each row holds one LSU plus COLS PEs.
- Generalises fixed 4-row one-hot init/run row decoding into a streamed configuration loader with valid/ready handshake, an iteration-counted run sweep with memory stall, and error detection.
- Sits between the top-level controller and the PE array rows. Drives each row's init_en/init_sel/run_en/run_sel and the shared pe_config bus.

Parameters:
ROWS, 4, number of PE rows
COLS, 3, PEs per row (units per row = COLS+1; unit 0 = LSU)
CFG_W, 32, configuration word width
ITER_W, 16, iteration count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config beat accepted when valid&ready
cfg_data  in  CFG_W  config word
cfg_last  in  1  marks final beat of a load
start  in  1  run request, sampled in READY only
iter_count  in  ITER_W  iterations, latched on accepted start
stall  in  1  memory backpressure, freezes run sweep
init_en  out  ROWS  one-hot row init strobe (bit r = row r)
init_sel  out  SEL_W  unit within row, SEL_W = max(1,$clog2(COLS+1))
pe_config  out  CFG_W  registered config word
run_en  out  ROWS  one-hot row run strobe
run_sel  out  SEL_W  unit within row being run
busy  out  1  high in LOAD or RUN
done  out  1  one-cycle pulse at run completion
cfg_err  out  1  sticky config framing error

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except cfg_ready; cfg_ready=1 from the first clock after release. Reset mid-load or mid-run discards everything; configuration is invalid.
- K = ROWS*(COLS+1) beats per load and cycles per iteration. Beat index b maps to row b/(COLS+1), unit b%(COLS+1), row-major.
- States: IDLE, LOAD, READY, RUN, DONE.
- cfg_ready = 1 in IDLE, LOAD, READY; 0 in RUN, DONE.
- Accepted beat in IDLE or READY: clears cfg_err, sets b=0, enters LOAD, and is itself beat 0.
- Each accepted beat b at cycle T drives init_en=onehot(row), init_sel=unit, pe_config=cfg_data at T+1, for one cycle. Otherwise init_en=0 and pe_config holds.
- cfg_last on beat b=K-1: enter READY.
- cfg_last on beat b<K-1: cfg_err=1, enter IDLE. The beat is still written.
- Beat K-1 without cfg_last: cfg_err=1, enter IDLE.
- start in READY (cycle T): latch N=iter_count.
  - N=0: go to DONE; done=1 at T+1, no run_en.
  - N>0: enter RUN. Issue cycles begin at T+1.
- RUN issue cycle: if stall=0, run_en=onehot(row), run_sel=unit, and the sweep index advances. If stall=1, run_en=0, run_sel holds, and the index holds.
- After N*K issued cycles, go to DONE. With no stalls, done=1 at T+N*K+1; each stalled cycle adds one.
- DONE lasts one cycle (done=1), then READY. Configuration is retained, so start may repeat without reload.
- start ignored outside READY. cfg_valid ignored in RUN/DONE (cfg_ready=0).
- Sweep counters sized to count K*N without overflow; the iteration counter is ITER_W bits.
- Outputs registered; no combinational path from inputs to outputs except cfg_ready (state-only).

Optional Feature:
- Macro PE_ARRAY_SEQ_PERF_EN.
- Defined: adds outputs perf_run_cycles[31:0] and perf_stall_cycles[31:0]. They count RUN cycles with stall=0 and stall=1 respectively, clear on accepted start, saturate at all-ones, and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with cfg_valid=0 -> all outputs 0; cfg_ready=1 after release; busy=0.
- Load 16 beats cfg_data=0x100+b, cfg_last on b=15 (defaults) -> beat 5 gives init_en=4'b0010, init_sel=1, pe_config=0x105 one cycle after acceptance; then READY, busy=0, cfg_err=0.
- After load, start with iter_count=2 at cycle T -> 32 run_en pulses cycling rows 0..3 and units 0..3; done at T+33; start again works without reload.
- Same run with stall=1 for 3 cycles mid-sweep -> run_en=0 during stall, no units skipped, done at T+36.
- cfg_last asserted on beat 7 -> cfg_err=1, state IDLE, subsequent start ignored (no run_en, no done); next accepted beat clears cfg_err.
- Loaded array, start with iter_count=0 -> done at T+1, run_en stays 0; rst pulse mid-RUN -> all outputs 0 immediately, start ignored until reload.
